// File: rtl/primocheck_if.sv
// Handshake bundle for the primality checker: the requester drives go/num,
// and the checker returns ready plus the registered result.
interface primocheck_if #(
  parameter int WIDTH_LOG = 4
);
  localparam int WIDTH = 1 << WIDTH_LOG;

  logic             go;
  logic [WIDTH-1:0] num;
  logic             ready;
  logic             is_prime;
  logic [WIDTH-1:0] factor;

  modport master (output go, output num, input ready, input is_prime, input factor);
  modport slave  (input go, input num, output ready, output is_prime, output factor);
endinterface

// File: rtl/primocheck.sv
// Primality checker: trial division by 2, then odd divisors 3, 5, 7, ...
// until divisor^2 exceeds the candidate, using a bit-serial restoring divider.
module primocheck #(
  parameter int WIDTH_LOG = 4
) (
  input  logic        clk,
  input  logic        rst,
  primocheck_if.slave bus
);
  localparam int WIDTH = 1 << WIDTH_LOG;
  localparam logic [2*WIDTH-1:0] DSQ_FOUR = {{(2*WIDTH-3){1'b0}}, 3'b100};

  typedef enum logic [1:0] {IDLE, CHECK, DIV, TEST} state_t;

  state_t               state, state_nx;
  logic [WIDTH-1:0]     n, n_nx;
  logic [WIDTH-1:0]     d, d_nx;
  logic [2*WIDTH-1:0]   dsq, dsq_nx;
  logic [WIDTH:0]       r, r_nx;
  logic [WIDTH_LOG-1:0] bit_idx, bit_idx_nx;
  logic                 ready, ready_nx;
  logic                 is_prime, is_prime_nx;
  logic [WIDTH-1:0]     factor, factor_nx;

  logic [WIDTH-1:0]     d_step;
  logic [2*WIDTH-1:0]   dsq_step;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  function automatic logic [WIDTH:0] div_step(input logic [WIDTH:0] rem,
                                               input logic nbit,
                                               input logic [WIDTH-1:0] dv);
    logic [WIDTH:0] sh;
    sh = {rem[WIDTH-1:0], nbit};
    if (sh >= {1'b0, dv}) sh = sh - {1'b0, dv};
    return sh;
  endfunction

  // (d+2)^2 = d^2 + 4d + 4, kept in double width so it never wraps.
  assign d_step   = d + WIDTH'(2);
  assign dsq_step = dsq + ({{WIDTH{1'b0}}, d} << 2) + DSQ_FOUR;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      n        <= '0;
      d        <= '0;
      dsq      <= '0;
      r        <= '0;
      bit_idx  <= '0;
      ready    <= 1'b1;
      is_prime <= 1'b0;
      factor   <= '0;
    end else begin
      state    <= state_nx;
      n        <= n_nx;
      d        <= d_nx;
      dsq      <= dsq_nx;
      r        <= r_nx;
      bit_idx  <= bit_idx_nx;
      ready    <= ready_nx;
      is_prime <= is_prime_nx;
      factor   <= factor_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    n_nx        = n;
    d_nx        = d;
    dsq_nx      = dsq;
    r_nx        = r;
    bit_idx_nx  = bit_idx;
    ready_nx    = ready;
    is_prime_nx = is_prime;
    factor_nx   = factor;

    case (state)
      IDLE: begin
        if (bus.go && ready) begin
          n_nx     = bus.num;
          ready_nx = 1'b0;
          state_nx = CHECK;
        end
      end

      CHECK: begin
        state_nx = IDLE;
        ready_nx = 1'b1;
        if (n < WIDTH'(2)) begin
          is_prime_nx = 1'b0;
          factor_nx   = '0;
        end else if (n == WIDTH'(2) || n == WIDTH'(3)) begin
          is_prime_nx = 1'b1;
          factor_nx   = '0;
        end else if (!n[0]) begin
          is_prime_nx = 1'b0;
          factor_nx   = WIDTH'(2);
        end else if (n < WIDTH'(9)) begin
          is_prime_nx = 1'b1;
          factor_nx   = '0;
        end else begin
          d_nx       = WIDTH'(3);
          dsq_nx     = (2*WIDTH)'(9);
          r_nx       = '0;
          bit_idx_nx = '1;
          ready_nx   = 1'b0;
          state_nx   = DIV;
        end
      end

      DIV: begin
        r_nx = div_step(r, n[bit_idx], d);
        if (bit_idx == '0) state_nx = TEST;
        else               bit_idx_nx = bit_idx - 1'b1;
      end

      TEST: begin
        if (r == '0) begin
          state_nx    = IDLE;
          ready_nx    = 1'b1;
          is_prime_nx = 1'b0;
          factor_nx   = d;
        end else if (dsq_step > {{WIDTH{1'b0}}, n}) begin
          state_nx    = IDLE;
          ready_nx    = 1'b1;
          is_prime_nx = 1'b1;
          factor_nx   = '0;
        end else begin
          d_nx       = d_step;
          dsq_nx     = dsq_step;
          r_nx       = '0;
          bit_idx_nx = '1;
          state_nx   = DIV;
        end
      end

      default: begin
        state_nx    = IDLE;
        ready_nx    = 1'b1;
        is_prime_nx = 1'b0;
        factor_nx   = '0;
      end
    endcase
  end

  assign bus.ready    = ready;
  assign bus.is_prime = is_prime;
  assign bus.factor   = factor;
endmodule

// File: doc/primocheck.md
Name: primocheck

Overview:
- Primality checker: the consumer/verifier counterpart to the prime generator.
- Accepts one candidate number per go handshake and reports whether it is prime. For composites it also reports the smallest non-trivial factor.
- Uses trial division by 2, then odd divisors 3, 5, 7, … until divisor² > candidate.
- Self-contained: has its own restoring divider and needs no divrem or RAM instance. Used by the benches to cross-check the generator and as a standalone accelerator.

Parameters:
- WIDTH_LOG, 4, log2 of data width. WIDTH = 1 << WIDTH_LOG.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted at 0).
- go  in  1  start request; sampled only while ready=1.
- num  in  WIDTH  candidate; captured on the clk edge where go=1 and ready=1.
- ready  out  1  1 = idle with valid result; 0 = busy.
- is_prime  out  1  result: 1 if the captured num is prime.
- factor  out  WIDTH  smallest divisor ≥2 if composite; 0 if prime or num<2.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, ready=1, is_prime=0, factor=0; internal registers cleared. Reset mid-check aborts at once, and no result is produced for the aborted candidate.
- All outputs are registered. Results hold stable from the rise of ready until the next accepted go.
- Handshake: go is accepted only when ready=1. The edge that accepts it latches num into n and moves to CHECK; ready=0 from that edge. go while busy is ignored (no queueing). num is ignored except on the accepting edge.
- States: IDLE, CHECK, DIV, TEST.
- CHECK (1 cycle):
  - n<2 → IDLE; is_prime=0, factor=0.
  - n=2 or n=3 → IDLE; is_prime=1, factor=0.
  - n even → IDLE; is_prime=0, factor=2.
  - n<9 (i.e. 5 or 7) → IDLE; is_prime=1, factor=0.
  - Otherwise load d=3, dsq=9, clear rem and bit counter → DIV.
- DIV (exactly WIDTH cycles): restoring divide, MSB first.
  - Each cycle: r = {r, n[bit]}; if r ≥ d then r = r − d.
  - r is WIDTH+1 bits wide.
  - After the WIDTH-th cycle → TEST.
- TEST (1 cycle):
  - r==0 → IDLE; is_prime=0, factor=d.
  - Otherwise: d_next = d+2 and dsq_next = dsq + 4·d + 4. If dsq_next > n → IDLE with is_prime=1, factor=0; else → DIV with d=d_next, dsq=dsq_next.
- Arithmetic widths:
  - dsq is 2·WIDTH bits, so it cannot overflow. The largest d reached is < 2^(WIDTH/2)+2.
  - d is WIDTH bits.
  - Comparisons are unsigned.
- Latency, counted from the accepting edge to the edge at which ready rises:
  - Trivial cases: 2 edges.
  - Each trial divisor adds WIDTH+1 edges, so k divisors give 2 + k·(WIDTH+1) − 1 + 1 = 1 + k·(WIDTH+1) + 1.
  - For WIDTH=16 with k divisors: 2 + 17k edges.
- Boundaries:
  - num = 2^WIDTH−1 must terminate correctly with no overflow.
  - go asserted continuously makes the block restart on the first edge after ready rises; back-to-back checks have no idle gap beyond that edge.
- Outputs are never X after reset. No X assignments in default branches: an illegal state returns to IDLE with ready=1 and results cleared.

Test Plan:
- After reset release, ready=1, is_prime=0, factor=0. Pulse go with num=0, then 1, then 2 → each reaches ready after 2 edges; results (0,0), (0,0), (1,0).
- num=9 (WIDTH=16) → ready rises 19 edges after acceptance; is_prime=0, factor=3. num=25 → is_prime=0, factor=5 after 2 divisors (36 edges).
- num=65521 → is_prime=1, factor=0. num=65535 → factor=3. num=65519 (=65519 prime? bench computes reference) → output matches the software reference.
- Sweep num=0..2000 against a software sieve, including go held high continuously → every is_prime and factor matches; go during busy never changes the result in progress.
- Pull rst low mid-DIV while checking 65521 → ready=1 immediately, outputs cleared. A subsequent go with num=97 → is_prime=1.
- Cross-check: connect to the generator's res on each of its ready pulses for its first 50 primes → is_prime=1 every time.
